serial_tx_frame: RTL

Parametrised successor to the fixed 8N1 serial transmitter: an asynchronous serial TX with configurable data width, optional parity, one or two stop bits, and a one-entry holding register. The holding register allows back-to-back frames with no idle gap on the line. It sits between the debug/host link logic and the board UART pin. The baud divider restarts on every frame, so the start-bit edge is cycle-exact relative to acceptance.

---
 rtl/serial_tx_frame.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/serial_tx_frame.sv
// Asynchronous serial transmitter: DATA_BITS payload, optional parity, 1/2 stop bits,
// one-entry holding register for gapless back-to-back frames. Parity logic only with SERIAL_TX_PARITY_EN.
module serial_tx_frame #(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 busy,
  output logic                 tx
);

  // state    | meaning
  // IDLE     | line high, nothing to send
  // START    | start bit (tx low)
  // DATA     | payload bits, LSB first
  // PARITY   | parity bit (only with SERIAL_TX_PARITY_EN)
  // STOP     | stop bit(s), hand-off point for the held word

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
    $error("serial_tx_frame: illegal parameter set");
  end

`ifdef SERIAL_TX_PARITY_EN
  localparam bit   PAR_ON  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 1);
  logic par_q, par_d;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 tx_d, busy_d, ready_d;

  logic                 accept, bit_end, load, take_direct;
  logic [DATA_BITS-1:0] load_word;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    take_direct = 1'b0;
    load_word   = data;
`ifdef SERIAL_TX_PARITY_EN
    par_d       = par_q;
`endif

    accept  = send && !hold_full_q;
    bit_end = (cnt_q == CNT_LAST);

    if (state_q != ST_IDLE)
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load        = 1'b1;
          take_direct = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            stop_d = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = PAR_ON ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            // End of frame: held word first, else a request arriving on this very edge.
            if (hold_full_q) begin
              load        = 1'b1;
              load_word   = hold_q;
              hold_full_d = 1'b0;
            end else if (accept) begin
              load        = 1'b1;
              take_direct = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d = ST_START;
      cnt_d   = '0;
      shift_d = load_word;
`ifdef SERIAL_TX_PARITY_EN
      par_d   = (^load_word) ^ PAR_ODD;
`endif
    end

    if (accept && !take_direct) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end

    // Line level follows the next state so tx changes on the same edge as the state.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase

    busy_d  = (state_d != ST_IDLE) || hold_full_d;
    ready_d = !hold_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      ready       <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx          <= tx_d;
      busy        <= busy_d;
      ready       <= ready_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

endmodule
